bus_arbiter_4: RTL and testbench

- Round-robin arbiter and sequencer for one shared 32-bit resource port, such as the data-memory or register-write path.
- Serves four requesters. Drives the 2-bit select of the 4:1 32-bit operand multiplexer and a one-hot grant vector.
- Holds the grant until the resource signals completion.
- Sits between the requesting pipeline units and the shared-resource mux, replacing fixed-priority select logic.

---
 rtl/bus_arbiter_4.sv | 160 ++++++++++++++++
 tb/tb_bus_arbiter_4.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter/sequencer for one shared 32-bit resource port with a 4:1 payload mux.
// Optional forced release of a stuck grant when ARB_TIMEOUT_EN is defined.
module bus_arbiter_4 #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [DATA_WIDTH-1:0] in_0,
  input  logic [DATA_WIDTH-1:0] in_1,
  input  logic [DATA_WIDTH-1:0] in_2,
  input  logic [DATA_WIDTH-1:0] in_3,
  input  logic                  done,
  output logic [3:0]            grant,
  output logic [1:0]            select,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_grant;
  logic [3:0]      w_grant_next;
  logic [1:0]      r_select;
  logic [1:0]      w_select_next;
  logic            r_busy;
  logic            w_busy_next;
  logic            r_timeout;
  logic            w_timeout_next;
  logic [1:0]      r_last;
  logic [1:0]      w_last_next;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_next;

  logic [3:0]      w_rot;
  logic [1:0]      w_off;
  logic [1:0]      w_winner;
  logic            w_req_any;
  logic            w_withdraw;
  logic            w_force;
  logic            w_release;
  logic [DATA_WIDTH-1:0] w_out;

  // Requests rotated so that bit 0 is the requester just after the last winner.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign w_rot[gi] = req[2'(r_last + 2'(gi + 1))];
    end
  endgenerate

  always_comb begin
    w_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_rot[k]) w_off = 2'(k);
    end
  end

  assign w_winner   = 2'(r_last + 2'd1 + w_off);
  assign w_req_any  = |req;
  assign w_withdraw = ~req[r_select];

`ifdef ARB_TIMEOUT_EN
  assign w_force = (r_cnt == 8'(TIMEOUT - 1)) && !done && req[r_select];
`else
  logic w_unused_timeout;
  assign w_force          = 1'b0;
  assign w_unused_timeout = ^{r_cnt, 8'(TIMEOUT)};
`endif

  // A simultaneous done and withdrawal is just one ordinary release.
  assign w_release = done | w_withdraw | w_force;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= 4'b0000;
      r_select  <= 2'b00;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 2'b11;
      r_cnt     <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_select  <= w_select_next;
      r_busy    <= w_busy_next;
      r_timeout <= w_timeout_next;
      r_last    <= w_last_next;
      r_cnt     <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_next = S_BUSY;
      S_BUSY:  if (w_release) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant_next   = r_grant;
    w_select_next  = r_select;
    w_busy_next    = r_busy;
    w_last_next    = r_last;
    w_cnt_next     = r_cnt;
    w_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_grant_next  = 4'b0001 << w_winner;
          w_select_next = w_winner;
          w_busy_next   = 1'b1;
          w_cnt_next    = 8'd0;
        end
      end
      S_BUSY: begin
        w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        if (w_release) begin
          w_grant_next   = 4'b0000;
          w_busy_next    = 1'b0;
          w_last_next    = r_select;
          w_timeout_next = w_force;
        end
      end
      default: begin
        w_grant_next = 4'b0000;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_out = '0;
    if (r_grant != 4'b0000) begin
      case (r_select)
        2'd0:    w_out = in_0;
        2'd1:    w_out = in_1;
        2'd2:    w_out = in_2;
        default: w_out = in_3;
      endcase
    end
  end

  assign grant   = r_grant;
  assign select  = r_select;
  assign busy    = r_busy;
  assign timeout = r_timeout;
  assign out     = w_out;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4: cycle table for arbitration order, hold, withdrawal
// and reset, plus a hand-written long-hold sequence for the timeout / no-timeout builds.
module tb_bus_arbiter_4;

  localparam int DW = 32;
  localparam logic [DW-1:0] P0 = 32'hA0A0_0000;
  localparam logic [DW-1:0] P1 = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] P2 = 32'h2222_5555;
  localparam logic [DW-1:0] P3 = 32'h3333_CCCC;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [DW-1:0] in_0, in_1, in_2, in_3;
  logic          done;
  logic [3:0]    grant;
  logic [1:0]    select;
  logic [DW-1:0] out;
  logic          busy;
  logic          timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int held;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] eg;
    logic [1:0] es;
    logic       eb;
  } vec_t;

  vec_t vq[$];

  bus_arbiter_4 #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .done(done), .grant(grant), .select(select), .out(out),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic d);
    reset = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic d,
                     input logic [3:0] eg, input logic [1:0] es, input logic eb);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.eg = eg; v.es = es; v.eb = eb;
    vq.push_back(v);
  endtask

  function automatic logic [DW-1:0] pay(input logic [3:0] g, input logic [1:0] s);
    if (g == 4'b0000) return '0;
    case (s)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  initial begin
    reset = 1'b1; req = 4'b0000; done = 1'b0;
    in_0 = P0; in_1 = P1; in_2 = P2; in_3 = P3;

    //   rst  req      done  grant    sel   busy
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0); // reset state
    add(1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1); // req 0 first after reset
    add(1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0); // done releases
    add(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1); // round robin -> 2
    add(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0);
    add(1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1); // back to 0
    add(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1); // done in IDLE ignored
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0); // out back to 0
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0); // idle holds
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1); // grant 2
    add(1'b0, 4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1); // other reqs toggle
    add(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b1101, 1'b1, 4'b0000, 2'd2, 1'b0);
    add(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1); // 3 beats 0 after pointer=2
    add(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1); // grant 1
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0); // withdrawal releases
    add(1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1); // pointer=1 -> 2
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0);
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1); // grant 3
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
    add(1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0); // reset mid-BUSY
    add(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1); // 0 wins after reset
    add(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0); // done + withdrawal together
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0); // reset beats req/done
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].req, vq[i].done);
      $display("vec %0d: rst=%b req=%b done=%b -> grant=%b select=%0d busy=%b out=%h timeout=%b",
               i, vq[i].rst, vq[i].req, vq[i].done, grant, select, busy, out, timeout);
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vq[i].eg));
      check($sformatf("v%0d_select", i), 32'(select), 32'(vq[i].es));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].eb));
      check($sformatf("v%0d_out", i), out, pay(vq[i].eg, vq[i].es));
      check($sformatf("v%0d_timeout", i), 32'(timeout), 32'd0);
    end

    // Long hold on requester 0 with done never asserted.
    step(1'b0, 4'b0001, 1'b0);
    $display("hold start: grant=%b select=%0d busy=%b", grant, select, busy);
    check("hold_grant", 32'(grant), 32'b0001);
`ifdef ARB_TIMEOUT_EN
    cyc = 41;
    for (int n = 1; n <= 40; n++) begin
      step(1'b0, 4'b0001, 1'b0);
      if (grant == 4'b0000) begin
        cyc = n;
        break;
      end
    end
    $display("timeout release after %0d cycles: grant=%b busy=%b timeout=%b", cyc, grant, busy, timeout);
    check("timeout_latency", 32'(cyc), 32'd16);
    check("timeout_pulse", 32'(timeout), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    step(1'b0, 4'b0011, 1'b0);
`else
    held = 0;
    for (int n = 0; n < 100; n++) begin
      step(1'b0, 4'b0001, 1'b0);
      if (grant == 4'b0001 && busy && !timeout) held++;
    end
    $display("hold 100 cycles: held=%0d grant=%b timeout=%b", held, grant, timeout);
    check("hold_100", 32'(held), 32'd100);
    step(1'b0, 4'b0001, 1'b1);
    $display("done release: grant=%b busy=%b timeout=%b", grant, busy, timeout);
    check("hold_release", 32'(grant), 32'd0);
    check("hold_no_timeout", 32'(timeout), 32'd0);
    step(1'b0, 4'b0011, 1'b0);
`endif
    $display("after release req=0011: grant=%b select=%0d timeout=%b", grant, select, timeout);
    check("post_grant", 32'(grant), 32'b0010);
    check("post_select", 32'(select), 32'd1);
    check("post_timeout", 32'(timeout), 32'd0);
    check("post_out", out, P1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
